pixel_bit_packer: RTL and testbench

PIXEL_BIT_PACKER -- requirements
Module: pixel_bit_packer

---
 rtl/pixel_bit_packer.sv | 163 ++++++++++++++++
 tb/tb_pixel_bit_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_bit_packer.sv
// Packs a stream of binarized pixels into WORD_W-bit words, one frame at a time.
// A frame ending early gets its partial word flushed and is flagged as short.
module pixel_bit_packer #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned FRAME_PIXELS = 307200
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iPIX,
    input  logic              iDVAL,
    input  logic              iFVAL,
    input  logic              iEN,
    output logic [WORD_W-1:0] oWORD,
    output logic              oWVAL,
    output logic [15:0]       oWORD_CNT,
    output logic              oFRAME_DONE,
    output logic              oSHORT,
    output logic              oBUSY
);

    localparam int unsigned     BitW      = $clog2(WORD_W);
    localparam logic [BitW-1:0] LastBit   = BitW'(WORD_W - 1);
    localparam logic [19:0]     FramePix  = 20'(FRAME_PIXELS);

    typedef enum logic [2:0] {StIdle, StArm, StPack, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic              fval_q;
    logic              arm_low_q, arm_low_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [19:0]       pix_q, pix_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              wval_q, wval_d;
    logic              done_q, done_d;
    logic              short_q, short_d;

    logic              accept;
    logic              fval_fall;
    logic              frame_full;
    logic [WORD_W-1:0] word_acc;

    // Pixels are only taken in PACK; the frame-start cycle itself carries none.
    assign accept     = (state_q == StPack) && iDVAL;
    assign fval_fall  = fval_q && !iFVAL;
    assign frame_full = accept && ((pix_q + 20'd1) == FramePix);

    always_comb begin
        word_acc        = word_q;
        word_acc[bit_q] = iPIX;
    end

    always_comb begin
        state_d   = state_q;
        arm_low_d = arm_low_q;
        word_d    = word_q;
        out_d     = out_q;
        bit_d     = bit_q;
        pix_d     = pix_q;
        cnt_d     = cnt_q;
        wval_d    = 1'b0;
        done_d    = 1'b0;
        short_d   = short_q;

        unique case (state_q)
            StIdle: begin
                if (iEN) begin
                    state_d   = StArm;
                    arm_low_d = 1'b0;
                end
            end
            StArm: begin
                // Requiring a low level first skips any frame already in flight.
                if (!iFVAL) begin
                    arm_low_d = 1'b1;
                end else if (arm_low_q) begin
                    state_d = StPack;
                    bit_d   = '0;
                    word_d  = '0;
                    pix_d   = '0;
                    cnt_d   = '0;
                    short_d = 1'b0;
                end
            end
            StPack: begin
                if (accept) begin
                    pix_d = pix_q + 20'd1;
                    if (bit_q == LastBit) begin
                        out_d  = word_acc;
                        wval_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                        bit_d  = '0;
                        word_d = '0;
                    end else begin
                        word_d = word_acc;
                        bit_d  = bit_q + 1'b1;
                    end
                end
                if (frame_full) begin
                    state_d = StDone;
                end else if (fval_fall) begin
                    short_d = 1'b1;
                    state_d = (bit_d != '0) ? StFlush : StDone;
                end
            end
            StFlush: begin
                out_d   = word_q;
                wval_d  = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                word_d  = '0;
                bit_d   = '0;
                state_d = StDone;
            end
            StDone: begin
                done_d = 1'b1;
                if (iEN) begin
                    state_d   = StArm;
                    arm_low_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= StIdle;
            fval_q    <= 1'b0;
            arm_low_q <= 1'b0;
            word_q    <= '0;
            out_q     <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
            cnt_q     <= '0;
            wval_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fval_q    <= iFVAL;
            arm_low_q <= arm_low_d;
            word_q    <= word_d;
            out_q     <= out_d;
            bit_q     <= bit_d;
            pix_q     <= pix_d;
            cnt_q     <= cnt_d;
            wval_q    <= wval_d;
            done_q    <= done_d;
            short_q   <= short_d;
        end
    end

    assign oWORD       = out_q;
    assign oWVAL       = wval_q;
    assign oWORD_CNT   = cnt_q;
    assign oFRAME_DONE = done_q;
    assign oSHORT      = short_q;
    assign oBUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_pixel_bit_packer.sv
// Directed bench for pixel_bit_packer with a 64-pixel frame and 32-bit words.
module tb_pixel_bit_packer;

    logic        CLOCK_50 = 1'b0;
    logic        DLY_RST_1 = 1'b1;
    logic        pix = 1'b0, dval = 1'b0, fval = 1'b0, en = 1'b0;
    logic [31:0] word;
    logic        wval, frame_done, short_flag, busy;
    logic [15:0] word_cnt;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q_word[$];
    int          q_wcyc[$];
    int          q_done[$];

    pixel_bit_packer #(.WORD_W(32), .FRAME_PIXELS(64)) dut (
        .iCLK(CLOCK_50), .iRST(DLY_RST_1), .iPIX(pix), .iDVAL(dval), .iFVAL(fval),
        .iEN(en), .oWORD(word), .oWVAL(wval), .oWORD_CNT(word_cnt),
        .oFRAME_DONE(frame_done), .oSHORT(short_flag), .oBUSY(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Output log: a word registered at edge N is seen here with cyc == N.
    always @(negedge CLOCK_50) begin
        if (wval) begin
            q_word.push_back(word);
            q_wcyc.push_back(cyc);
        end
        if (frame_done) q_done.push_back(cyc);
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        q_word.delete();
        q_wcyc.delete();
        q_done.delete();
    endtask

    task automatic send_pixel(input logic p, output int acc);
        dval = 1'b1;
        pix  = p;
        step();
        acc  = cyc;
        dval = 1'b0;
    endtask

    // Assumes the DUT is in ARM; leaves it in PACK with no pixel yet taken.
    task automatic start_frame();
        fval = 1'b0;
        steps(3);
        fval = 1'b1;
        steps(2);
    endtask

    task automatic test_reset();
        DLY_RST_1 = 1'b1;
        steps(2);
        n_vec++; if (word !== 32'h0) begin n_err++; $display("FAIL reset_word got %h want 0", word); end
        n_vec++; if (wval !== 1'b0) begin n_err++; $display("FAIL reset_wval got %b want 0", wval); end
        n_vec++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", word_cnt); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", frame_done); end
        n_vec++; if (short_flag !== 1'b0) begin n_err++; $display("FAIL reset_short got %b want 0", short_flag); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        DLY_RST_1 = 1'b0;
        step();
    endtask

    task automatic test_full_frame();
        int acc;
        en = 1'b1;
        step();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy got %b want 1", busy); end
        start_frame();
        clear_log();
        for (int k = 0; k < 64; k++) send_pixel(~k[0], acc);
        steps(4);
        fval = 1'b0;
        steps(2);
        n_vec++; if (q_word.size() !== 2) begin n_err++; $display("FAIL full_nwords got %0d want 2", q_word.size()); end
        n_vec++; if (q_word[0] !== 32'h55555555) begin n_err++; $display("FAIL full_word0 got %h want 55555555", q_word[0]); end
        n_vec++; if (q_word[1] !== 32'h55555555) begin n_err++; $display("FAIL full_word1 got %h want 55555555", q_word[1]); end
        n_vec++; if (q_wcyc[1] !== acc) begin n_err++; $display("FAIL full_latency got %0d want %0d", q_wcyc[1], acc); end
        n_vec++; if (word_cnt !== 16'd2) begin n_err++; $display("FAIL full_cnt got %0d want 2", word_cnt); end
        n_vec++; if (q_done.size() !== 1) begin n_err++; $display("FAIL full_ndone got %0d want 1", q_done.size()); end
        n_vec++; if (q_done[0] !== acc + 1) begin n_err++; $display("FAIL full_done_cyc got %0d want %0d", q_done[0], acc + 1); end
        n_vec++; if (short_flag !== 1'b0) begin n_err++; $display("FAIL full_short got %b want 0", short_flag); end
    endtask

    task automatic test_short_flush();
        int acc;
        start_frame();
        clear_log();
        for (int k = 0; k < 40; k++) send_pixel(1'b1, acc);
        fval = 1'b0;
        steps(5);
        n_vec++; if (q_word.size() !== 2) begin n_err++; $display("FAIL short_nwords got %0d want 2", q_word.size()); end
        n_vec++; if (q_word[0] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL short_word0 got %h want ffffffff", q_word[0]); end
        n_vec++; if (q_word[1] !== 32'h000000FF) begin n_err++; $display("FAIL short_flush got %h want 000000ff", q_word[1]); end
        n_vec++; if (q_wcyc[1] !== acc + 2) begin n_err++; $display("FAIL short_flush_cyc got %0d want %0d", q_wcyc[1], acc + 2); end
        n_vec++; if (q_done[0] !== acc + 3) begin n_err++; $display("FAIL short_done_cyc got %0d want %0d", q_done[0], acc + 3); end
        n_vec++; if (short_flag !== 1'b1) begin n_err++; $display("FAIL short_flag got %b want 1", short_flag); end
        n_vec++; if (word_cnt !== 16'd2) begin n_err++; $display("FAIL short_cnt got %0d want 2", word_cnt); end
    endtask

    task automatic test_gapped_valid();
        int acc;
        start_frame();
        clear_log();
        n_vec++; if (short_flag !== 1'b0) begin n_err++; $display("FAIL gap_short_clear got %b want 0", short_flag); end
        for (int k = 0; k < 32; k++) begin
            send_pixel(k[0], acc);
            step();
            if (k == 10) en = 1'b0;   // dropping enable must not cut the frame
        end
        fval = 1'b0;
        steps(5);
        n_vec++; if (q_word.size() !== 1) begin n_err++; $display("FAIL gap_nwords got %0d want 1", q_word.size()); end
        n_vec++; if (q_word[0] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL gap_word got %h want aaaaaaaa", q_word[0]); end
        n_vec++; if (q_wcyc[0] !== acc) begin n_err++; $display("FAIL gap_latency got %0d want %0d", q_wcyc[0], acc); end
        n_vec++; if (word !== 32'hAAAAAAAA) begin n_err++; $display("FAIL gap_hold got %h want aaaaaaaa", word); end
        n_vec++; if (q_done.size() !== 1) begin n_err++; $display("FAIL gap_ndone got %0d want 1", q_done.size()); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_idle got %b want 0", busy); end
    endtask

    task automatic test_mid_frame_arm();
        int acc;
        fval = 1'b1;
        steps(2);
        en = 1'b1;
        clear_log();
        for (int k = 0; k < 40; k++) send_pixel(1'b1, acc);
        fval = 1'b0;
        steps(3);
        n_vec++; if (q_word.size() !== 0) begin n_err++; $display("FAIL arm_skip_words got %0d want 0", q_word.size()); end
        n_vec++; if (q_done.size() !== 0) begin n_err++; $display("FAIL arm_skip_done got %0d want 0", q_done.size()); end
        start_frame();
        for (int k = 0; k < 8; k++) send_pixel(1'b1, acc);
        fval = 1'b0;
        steps(5);
        n_vec++; if (q_word.size() !== 1) begin n_err++; $display("FAIL arm_nwords got %0d want 1", q_word.size()); end
        n_vec++; if (q_word[0] !== 32'h000000FF) begin n_err++; $display("FAIL arm_word got %h want 000000ff", q_word[0]); end
        n_vec++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL arm_cnt got %0d want 1", word_cnt); end
    endtask

    task automatic test_boundary();
        int acc;
        start_frame();
        clear_log();
        for (int k = 0; k < 31; k++) send_pixel(1'b1, acc);
        fval = 1'b0;
        send_pixel(1'b1, acc);
        steps(4);
        n_vec++; if (q_word.size() !== 1) begin n_err++; $display("FAIL bnd_nwords got %0d want 1", q_word.size()); end
        n_vec++; if (q_word[0] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bnd_word got %h want ffffffff", q_word[0]); end
        n_vec++; if (q_done.size() !== 1) begin n_err++; $display("FAIL bnd_ndone got %0d want 1", q_done.size()); end
        n_vec++; if (q_done[0] !== acc + 1) begin n_err++; $display("FAIL bnd_done_cyc got %0d want %0d", q_done[0], acc + 1); end
        n_vec++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL bnd_cnt got %0d want 1", word_cnt); end
        n_vec++; if (short_flag !== 1'b1) begin n_err++; $display("FAIL bnd_short got %b want 1", short_flag); end
    endtask

    task automatic test_reset_abort();
        int acc;
        start_frame();
        for (int k = 0; k < 20; k++) send_pixel(1'b1, acc);
        clear_log();
        #1 DLY_RST_1 = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        n_vec++; if (word !== 32'h0) begin n_err++; $display("FAIL abort_word got %h want 0", word); end
        n_vec++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL abort_cnt got %0d want 0", word_cnt); end
        n_vec++; if (short_flag !== 1'b0) begin n_err++; $display("FAIL abort_short got %b want 0", short_flag); end
        steps(2);
        DLY_RST_1 = 1'b0;
        for (int k = 0; k < 20; k++) send_pixel(1'b1, acc);
        fval = 1'b0;
        steps(2);
        n_vec++; if (q_word.size() !== 0) begin n_err++; $display("FAIL abort_words got %0d want 0", q_word.size()); end
        n_vec++; if (q_done.size() !== 0) begin n_err++; $display("FAIL abort_done got %0d want 0", q_done.size()); end
        start_frame();
        for (int k = 0; k < 32; k++) send_pixel(~k[0], acc);
        fval = 1'b0;
        steps(4);
        n_vec++; if (q_word.size() !== 1) begin n_err++; $display("FAIL abort_next_nwords got %0d want 1", q_word.size()); end
        n_vec++; if (q_word[0] !== 32'h55555555) begin n_err++; $display("FAIL abort_next_word got %h want 55555555", q_word[0]); end
        n_vec++; if (q_wcyc[0] !== acc) begin n_err++; $display("FAIL abort_next_cyc got %0d want %0d", q_wcyc[0], acc); end
        n_vec++; if (q_done.size() !== 1) begin n_err++; $display("FAIL abort_next_done got %0d want 1", q_done.size()); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_flush();
        test_gapped_valid();
        test_mid_frame_arm();
        test_boundary();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
